// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, timing multipliers and ASCII codes.
// Used by the receive decoder and the transmit encoder table.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_EMIT,
        ST_GAP,
        ST_ERR
    } state_t;

    localparam int unsigned MUL_DASH = 2;
    localparam int unsigned MUL_WORD = 5;
    localparam int unsigned MUL_ERR  = 7;
    localparam int unsigned MAX_SYM  = 5;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_sym_lut.sv
// Symbol pattern to ASCII table; first symbol sits at bit len-1, last at bit 0.
// dot = 0, dash = 1; unused upper sym bits are zero.
module morse_sym_lut
    import morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [4:0] sym,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_UNKNOWN;
        case ({len, sym})
            {3'd2, 5'b00001}: ascii = 8'h41;
            {3'd4, 5'b01000}: ascii = 8'h42;
            {3'd4, 5'b01010}: ascii = 8'h43;
            {3'd3, 5'b00100}: ascii = 8'h44;
            {3'd1, 5'b00000}: ascii = 8'h45;
            {3'd4, 5'b00010}: ascii = 8'h46;
            {3'd3, 5'b00110}: ascii = 8'h47;
            {3'd4, 5'b00000}: ascii = 8'h48;
            {3'd2, 5'b00000}: ascii = 8'h49;
            {3'd4, 5'b00111}: ascii = 8'h4A;
            {3'd3, 5'b00101}: ascii = 8'h4B;
            {3'd4, 5'b00100}: ascii = 8'h4C;
            {3'd2, 5'b00011}: ascii = 8'h4D;
            {3'd2, 5'b00010}: ascii = 8'h4E;
            {3'd3, 5'b00111}: ascii = 8'h4F;
            {3'd4, 5'b00110}: ascii = 8'h50;
            {3'd4, 5'b01101}: ascii = 8'h51;
            {3'd3, 5'b00010}: ascii = 8'h52;
            {3'd3, 5'b00000}: ascii = 8'h53;
            {3'd1, 5'b00001}: ascii = 8'h54;
            {3'd3, 5'b00001}: ascii = 8'h55;
            {3'd4, 5'b00001}: ascii = 8'h56;
            {3'd3, 5'b00011}: ascii = 8'h57;
            {3'd4, 5'b01001}: ascii = 8'h58;
            {3'd4, 5'b01011}: ascii = 8'h59;
            {3'd4, 5'b01100}: ascii = 8'h5A;
            {3'd5, 5'b11111}: ascii = 8'h30;
            {3'd5, 5'b01111}: ascii = 8'h31;
            {3'd5, 5'b00111}: ascii = 8'h32;
            {3'd5, 5'b00011}: ascii = 8'h33;
            {3'd5, 5'b00001}: ascii = 8'h34;
            {3'd5, 5'b00000}: ascii = 8'h35;
            {3'd5, 5'b10000}: ascii = 8'h36;
            {3'd5, 5'b11000}: ascii = 8'h37;
            {3'd5, 5'b11100}: ascii = 8'h38;
            {3'd5, 5'b11110}: ascii = 8'h39;
            default:          ascii = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: key timing FSM, symbol collection and 1-deep char output.
// Optional key deglitch filter enabled by defining MORSE_RX_DEGLITCH_EN.
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYC     = 1000,
    parameter int CNT_W        = 16,
    parameter int DEGLITCH_CYC = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_in,
    input  logic       char_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       err,
    output logic       overrun
);

    // Thresholds are compared one cycle early so the state change lands
    // on the same edge where cnt reaches the multiple.
    localparam logic [CNT_W-1:0] T_DASH = CNT_W'(MUL_DASH * UNIT_CYC - 1);
    localparam logic [CNT_W-1:0] T_WORD = CNT_W'(MUL_WORD * UNIT_CYC - 1);
    localparam logic [CNT_W-1:0] T_ERR  = CNT_W'(MUL_ERR * UNIT_CYC - 1);
    localparam logic [CNT_W-1:0] T_SAT  = CNT_W'(MUL_ERR * UNIT_CYC);

    logic sync1;
    logic sync2;
    logic key_s;
    logic key_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

`ifdef MORSE_RX_DEGLITCH_EN
    localparam int DW = (DEGLITCH_CYC > 1) ? $clog2(DEGLITCH_CYC) : 1;

    logic [DW-1:0] dg_cnt;
    logic          dg_hit;

    assign dg_hit  = (sync2 != key_s) && (dg_cnt == DW'(DEGLITCH_CYC - 1));
    assign key_nxt = dg_hit ? sync2 : key_s;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_s  <= 1'b0;
            dg_cnt <= '0;
        end else begin
            key_s <= key_nxt;
            if (sync2 == key_s || dg_hit)
                dg_cnt <= '0;
            else
                dg_cnt <= dg_cnt + 1'b1;
        end
    end
`else
    logic unused_dg;

    assign key_s     = sync2;
    assign key_nxt   = sync1;
    assign unused_dg = (DEGLITCH_CYC == 0);
`endif

    logic rise;
    logic fall;

    assign rise = key_nxt & ~key_s;
    assign fall = key_s & ~key_nxt;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        sym;
    logic [4:0]        sym_n;
    logic [2:0]        len;
    logic [2:0]        len_n;
    logic              err_n;
    logic              emit;
    logic [7:0]        emit_chr;
    logic [7:0]        lut_out;
    logic              accept;

    morse_sym_lut u_lut (
        .len   (len),
        .sym   (sym),
        .ascii (lut_out)
    );

    always_comb begin
        state_n  = state;
        sym_n    = sym;
        len_n    = len;
        err_n    = 1'b0;
        emit     = 1'b0;
        emit_chr = lut_out;
        unique case (state)
            ST_IDLE: begin
                if (rise)
                    state_n = ST_MARK;
            end
            ST_MARK: begin
                if (cnt >= T_ERR || (fall && len == 3'(MAX_SYM))) begin
                    state_n = ST_ERR;
                    err_n   = 1'b1;
                    sym_n   = '0;
                    len_n   = '0;
                end else if (fall) begin
                    sym_n   = {sym[3:0], (cnt >= T_DASH)};
                    len_n   = len + 3'd1;
                    state_n = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (rise)
                    state_n = ST_MARK;
                else if (cnt >= T_DASH)
                    state_n = ST_EMIT;
            end
            ST_EMIT: begin
                emit    = 1'b1;
                sym_n   = '0;
                len_n   = '0;
                state_n = rise ? ST_MARK : ST_GAP;
            end
            ST_GAP: begin
                if (rise) begin
                    state_n = ST_MARK;
                end else if (cnt >= T_WORD) begin
                    emit     = 1'b1;
                    emit_chr = ASCII_SPACE;
                    state_n  = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (!key_s && !key_nxt && cnt >= T_DASH)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Accepting and loading in the same cycle counts as a load.
    assign accept = !char_valid || char_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sym        <= '0;
            len        <= '0;
            err        <= 1'b0;
            char_data  <= 8'h00;
            char_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_n;
            sym   <= sym_n;
            len   <= len_n;
            err   <= err_n;
            if (key_nxt != key_s)
                cnt <= '0;
            else if (cnt != T_SAT)
                cnt <= cnt + 1'b1;
            if (emit && accept) begin
                char_data  <= emit_chr;
                char_valid <= 1'b1;
            end else begin
                if (char_ready)
                    char_valid <= 1'b0;
                if (emit)
                    overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder: segment-level Morse model plus directed checks.
// Define MORSE_RX_DEGLITCH_EN to exercise the deglitch filter.
module tb_morse_rx_decoder;

    localparam int U = 4;
`ifdef MORSE_RX_DEGLITCH_EN
    localparam int DGC  = 4;
    localparam int LAT  = 2 + DGC;
    localparam int MINL = DGC;
`else
    localparam int DGC  = 8;
    localparam int LAT  = 2;
    localparam int MINL = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       key_in = 1'b0;
    logic       char_ready = 1'b1;
    logic [7:0] char_data;
    logic       char_valid;
    logic       err;
    logic       overrun;

    morse_rx_decoder #(
        .UNIT_CYC     (U),
        .CNT_W        (16),
        .DEGLITCH_CYC (DGC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .key_in     (key_in),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_valid (char_valid),
        .err        (err),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int  t;
        bit  is_err;
        byte ch;
    } ev_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   err_seen = 0;
    ev_t  evq[$];
    byte  rxq[$];
    string letter = "";
    bit   in_err = 1'b0;

    logic [7:0] data_m = 8'h00;
    bit   val_m = 1'b0;
    bit   err_m = 1'b0;
    bit   ov_m = 1'b0;
    ev_t  cur;
    bit   ld;
    byte  chm;

    string codes [0:35] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
        "--...", "---..", "----."
    };
    string alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic byte decode(input string code);
        for (int i = 0; i < 36; i++)
            if (codes[i] == code)
                return alph[i];
        return 8'h3F;
    endfunction

    function automatic byte qget(input int i);
        if (i < rxq.size())
            return rxq[i];
        return 8'h00;
    endfunction

    task automatic push_ev(input int t, input bit e, input byte c);
        ev_t x;
        x.t = t;
        x.is_err = e;
        x.ch = c;
        evq.push_back(x);
    endtask

    // Drive one key segment and record what the spec says it produces.
    task automatic model_seg(input bit lvl, input int len);
        int t0;
        t0 = cyc + LAT;
        key_in = lvl;
        if (lvl) begin
            if (in_err) begin
            end else if (len >= 7 * U) begin
                push_ev(t0 + 7 * U, 1'b1, 8'h00);
                in_err = 1'b1;
                letter = "";
            end else if (letter.len() == 5) begin
                push_ev(t0 + len, 1'b1, 8'h00);
                in_err = 1'b1;
                letter = "";
            end else begin
                letter = {letter, (len < 2 * U) ? "." : "-"};
            end
        end else begin
            if (in_err) begin
                if (len >= 2 * U)
                    in_err = 1'b0;
            end else if (letter.len() > 0 && len >= 2 * U) begin
                push_ev(t0 + 2 * U + 1, 1'b0, decode(letter));
                letter = "";
                if (len >= 5 * U)
                    push_ev(t0 + 5 * U, 1'b0, 8'h20);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic seg(input bit lvl, input int len);
        model_seg(lvl, len);
        wait_cyc(len);
    endtask

    task automatic send_code(input string code, input int gap);
        for (int i = 0; i < code.len(); i++) begin
            if (code[i] == 8'h2E)
                seg(1'b1, int'($urandom_range(6, MINL)));
            else
                seg(1'b1, int'($urandom_range(20, 9)));
            if (i < code.len() - 1)
                seg(1'b0, int'($urandom_range(6, MINL)));
        end
        seg(1'b0, gap);
    endtask

    // Reference output register, advanced once per clock edge.
    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RST) begin
            val_m = 1'b0;
            data_m = 8'h00;
            err_m = 1'b0;
            ov_m = 1'b0;
        end else begin
            err_m = 1'b0;
            ld = 1'b0;
            chm = 8'h00;
            while (evq.size() > 0 && evq[0].t <= cyc) begin
                cur = evq.pop_front();
                if (cur.is_err)
                    err_m = 1'b1;
                else begin
                    ld = 1'b1;
                    chm = cur.ch;
                end
            end
            if (ld && (!val_m || char_ready)) begin
                data_m = chm;
                val_m = 1'b1;
            end else begin
                if (char_ready)
                    val_m = 1'b0;
                if (ld)
                    ov_m = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RST) begin
            chk("rst_valid", char_valid, 0);
            chk("rst_err", err, 0);
        end else begin
            chk("char_valid", char_valid, val_m);
            chk("char_data", char_data, data_m);
            chk("err", err, err_m);
            chk("overrun", overrun, ov_m);
        end
        if (err === 1'b1)
            err_seen++;
        if (char_valid === 1'b1 && char_ready === 1'b1)
            rxq.push_back(char_data);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int nf;
        int e0;
        int r;
        int nsym;
        string code;

        wait_cyc(3);
        chk("reset_data", char_data, 8'h00);
        chk("reset_valid", char_valid, 0);
        chk("reset_err", err, 0);
        chk("reset_overrun", overrun, 0);
        RST = 1'b0;
        seg(1'b0, 10);

        // 'E' with exact latency points
        rxq.delete();
        seg(1'b1, 4);
        nf = cyc;
        model_seg(1'b0, 30);
        wait_cyc(LAT + 2 * U);
        chk("e_not_yet", char_valid, 0);
        wait_cyc(1);
        chk("e_valid", char_valid, 1);
        chk("e_data", char_data, 8'h45);
        wait_cyc(5 * U - 2 * U - 1);
        chk("e_space_data", char_data, 8'h20);
        chk("e_space_valid", char_valid, 1);
        wait_cyc(30 - (LAT + 5 * U));

        // SOS
        rxq.delete();
        send_code("...", 12);
        send_code("---", 12);
        send_code("...", 28);
        chk("sos_count", rxq.size(), 4);
        chk("sos_0", qget(0), 8'h53);
        chk("sos_1", qget(1), 8'h4F);
        chk("sos_2", qget(2), 8'h53);
        chk("sos_3", qget(3), 8'h20);
        chk("sos_overrun", overrun, 0);

        // over-long mark, then 'T'
        rxq.delete();
        e0 = err_seen;
        seg(1'b1, 30);
        seg(1'b0, 10);
        send_code("-", 28);
        chk("long_err_count", err_seen - e0, 1);
        chk("long_t", qget(0), 8'h54);
        chk("long_count", rxq.size(), 2);

        // six symbols, then an unknown pattern
        rxq.delete();
        e0 = err_seen;
        send_code("......", 28);
        chk("six_err_count", err_seen - e0, 1);
        chk("six_nothing", rxq.size(), 0);
        send_code("..--", 28);
        chk("unk_data", qget(0), 8'h3F);
        chk("unk_count", rxq.size(), 2);

        // backpressure: 'A' held, 'N' dropped
        char_ready = 1'b0;
        send_code(".-", 12);
        send_code("-.", 28);
        chk("bp_data", char_data, 8'h41);
        chk("bp_valid", char_valid, 1);
        chk("bp_overrun", overrun, 1);
        char_ready = 1'b1;

        // reset in the middle of 'K'
        seg(1'b1, 14);
        seg(1'b0, 4);
        key_in = 1'b1;
        wait_cyc(2);
        RST = 1'b1;
        key_in = 1'b0;
        letter = "";
        in_err = 1'b0;
        evq.delete();
        wait_cyc(2);
        chk("mid_rst_data", char_data, 8'h00);
        chk("mid_rst_valid", char_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_err", err, 0);
        RST = 1'b0;
        seg(1'b0, 30);
`ifdef MORSE_RX_DEGLITCH_EN
        e0 = err_seen;
        rxq.delete();
        key_in = 1'b1;
        wait_cyc(3);
        key_in = 1'b0;
        wait_cyc(30);
        chk("glitch_valid", char_valid, 0);
        chk("glitch_rx", rxq.size(), 0);
        chk("glitch_err", err_seen - e0, 0);
`endif
        rxq.delete();
        send_code("-.-", 28);
        chk("after_rst_k", qget(0), 8'h4B);

        // randomized letters, words, errors and backpressure
        for (int k = 0; k < 40; k++) begin
            char_ready = ($urandom_range(9, 0) < 8);
            r = int'($urandom_range(14, 0));
            if (r == 0) begin
                seg(1'b1, int'($urandom_range(36, 29)));
                seg(1'b0, int'($urandom_range(30, 10)));
            end else begin
                nsym = (r == 1) ? 6 : int'($urandom_range(5, 1));
                code = "";
                for (int j = 0; j < nsym; j++)
                    code = {code, ($urandom_range(1, 0) != 0) ? "-" : "."};
                if ($urandom_range(1, 0) != 0)
                    send_code(code, int'($urandom_range(18, 10)));
                else
                    send_code(code, int'($urandom_range(34, 22)));
            end
        end
        char_ready = 1'b1;
        seg(1'b0, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
